sfq_dff_array: RTL and testbench
================================

// Module: sfq_dff_array
// PURPOSE
//  Cycle-based behavioural model of N independent RSFQ D flip-flops sharing one readout
//  (clock) pulse line. SFQ pulses are one-cycle strobes on clk.
//  Each channel keeps the cell state machine: a set pulse stores a fluxon, readout emits it.
//  Adds per-channel double-set error flags, setup/hold window checks and DRO/NDRO readout.
//  Sits between TimEx-style pulse stimulus and cell-level models in gate-level SFQ netlists.
// PARAMETERS
//  N_CH       4   number of flip-flop channels (1..32)
//  SETUP_CYC  2   min cycles between set and rd on a channel (0 disables the check)
//  HOLD_CYC   1   min cycles between rd and a following set (0 disables the check)
//  NDRO       0   0: destructive readout (rd clears state); 1: non-destructive (only clr_i clears)
//  CNT_W      4   width of the saturating window counters; must hold max(SETUP_CYC,HOLD_CYC)
// PORTS
//  clk        in   1      model time base; every event is sampled on the rising edge
//  rst_n      in   1      asynchronous reset, active low
//  set_i      in   N_CH   set (data) pulse per channel, one-cycle strobe
//  rd_i       in   1      common readout/clock pulse, one-cycle strobe
//  clr_i      in   N_CH   per-channel clear pulse, no output (used in NDRO mode; also legal in DRO)
//  flag_clr_i in   1      clears all sticky err_o/viol_o bits
//  out_o      out  N_CH   output pulse, one cycle, registered
//  state_o    out  N_CH   current stored state (1 = fluxon stored)
//  err_o      out  N_CH   sticky: set pulse arrived while state already 1
//  viol_o     out  N_CH   sticky: setup or hold window violated
// BEHAVIOUR
//  - Reset (rst_n=0, async): state, out_o, err_o, viol_o all 0; counters at saturation (no violation).
//  - States per channel: S0 (empty), S1 (stored). No error state; errors are flagged only.
//  - S0 + set_i -> S1. S1 + set_i -> stays S1, err_o=1 (pulse lost, no output).
//  - rd_i: out_o[c] <= state[c] on the same edge; pulse visible 1 cycle after rd_i, width 1 cycle.
//    DRO: state -> S0. NDRO: state unchanged.
//  - clr_i[c]: state -> S0, out_o unaffected; clr has priority over set in the same cycle.
//  - Same-cycle set_i and rd_i: readout uses the pre-edge state; set then applies (state=1,
//    and in S1 it still counts as a double-set error in NDRO). Also flags a setup violation.
//  - Setup check: per-channel counter cleared on set_i, +1 per cycle, saturating at 2^CNT_W-1.
//    rd_i with state=1 and counter < SETUP_CYC -> viol_o[c]=1.
//  - Hold check: shared counter cleared on rd_i; set_i[c] with counter < HOLD_CYC -> viol_o[c]=1.
//    The set is still accepted.
//  - flag_clr_i clears flags first; a new error in the same cycle re-sets the flag (event wins).
//  - Reset mid-pulse: everything drops immediately; the first edge after release is treated as idle.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Package sfq_pkg: typedef for channel state (S0/S1), saturating-counter max localparam,
//    and the shared pulse-strobe conventions used by the other SFQ cell models.
//  - One sub-module, sfq_dff_cell: a single channel (state, setup counter, flags).
//    The top generates N_CH instances plus the shared hold counter and rd_i fan-out.
// TESTING
//  1 DRO basic: set_i=4'b0001 @20, rd_i @30 -> out_o=4'b0001 for exactly one cycle @31,
//    state_o=0, no flags.
//  2 Double set: set_i[2] @10 and @14, rd_i @20 -> err_o[2]=1, single out_o[2] pulse @21.
//  3 Setup: SETUP_CYC=2, set_i[1] @10, rd_i @11 -> viol_o[1]=1, out_o[1] still pulses @12.
//    Same-cycle set/rd on ch0 -> out_o[0]=0, state_o[0]=1, viol_o[0]=1.
//  4 Hold: rd_i @30, set_i[3] @30 (HOLD_CYC=1) -> viol_o[3]=1. Set @32 -> no flag.
//  5 NDRO=1: set_i[0], rd_i three times -> three out_o[0] pulses; clr_i[0] then rd_i -> no pulse.
//  6 Async reset: assert rst_n=0 between clock edges with state=4'hF and flags set -> all outputs
//    0 before the next edge; flag_clr_i+error same cycle -> flag stays 1.

Source files
------------

// File: rtl/sfq_pkg.sv
// Shared types and constants for the cycle-based RSFQ cell models.
// Pulses are one-cycle active-high strobes sampled on the rising clock edge.
package sfq_pkg;

    typedef enum logic {
        S0 = 1'b0,  // empty
        S1 = 1'b1   // fluxon stored
    } ch_state_e;

    localparam logic PulseOn  = 1'b1;
    localparam logic PulseOff = 1'b0;

    localparam int unsigned CntWDefault   = 4;
    localparam int unsigned CntMaxDefault = (1 << CntWDefault) - 1;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sfq_dff_cell.sv
// One RSFQ D flip-flop channel: stored fluxon, setup-window counter and sticky flags.
// The hold check is evaluated by the parent and arrives as hold_short_i.
module sfq_dff_cell
    import sfq_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter bit          NDRO      = 1'b0,
    parameter int unsigned CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic rd_i,
    input  logic clr_i,
    input  logic flag_clr_i,
    input  logic hold_short_i,
    output logic out_o,
    output logic state_o,
    output logic err_o,
    output logic viol_o
);

    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W:0]   SetupLim = (CNT_W+1)'(SETUP_CYC);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [CNT_W:0]   setup_dist;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             viol_q, viol_d;
    logic             err_ev, setup_ev, hold_ev;

    always_comb begin
        // Distance in cycles from the last set to this edge.
        setup_dist = {1'b0, setup_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        setup_ev = (SETUP_CYC != 0) && rd_i &&
                   (set_i || ((state_q == S1) && (setup_dist < SetupLim)));
        hold_ev  = set_i && hold_short_i;
        // In DRO a same-edge readout empties the cell before the set lands.
        err_ev   = set_i && (state_q == S1) && (NDRO || !rd_i);

        out_d = rd_i ? (state_q == S1) : PulseOff;

        state_d = state_q;
        if (clr_i) begin
            state_d = S0;
        end else if (set_i) begin
            state_d = S1;
        end else if (rd_i && !NDRO) begin
            state_d = S0;
        end

        if (set_i) begin
            setup_cnt_d = '0;
        end else if (setup_cnt_q == CntMax) begin
            setup_cnt_d = CntMax;
        end else begin
            setup_cnt_d = setup_cnt_q + CntOne;
        end

        err_d  = (err_q && !flag_clr_i) || err_ev;
        viol_d = (viol_q && !flag_clr_i) || setup_ev || hold_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S0;
            setup_cnt_q <= CntMax;
            out_q       <= PulseOff;
            err_q       <= 1'b0;
            viol_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            out_q       <= out_d;
            err_q       <= err_d;
            viol_q      <= viol_d;
        end
    end

    assign out_o   = out_q;
    assign state_o = (state_q == S1);
    assign err_o   = err_q;
    assign viol_o  = viol_q;

endmodule

// File: rtl/sfq_dff_array.sv
// N independent RSFQ D flip-flops sharing one readout pulse line.
// Owns the shared hold-window counter and fans rd_i out to every channel.
module sfq_dff_array
    import sfq_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter bit          NDRO      = 1'b0,
    parameter int unsigned CNT_W     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] set_i,
    input  logic            rd_i,
    input  logic [N_CH-1:0] clr_i,
    input  logic            flag_clr_i,
    output logic [N_CH-1:0] out_o,
    output logic [N_CH-1:0] state_o,
    output logic [N_CH-1:0] err_o,
    output logic [N_CH-1:0] viol_o
);

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W:0]   HoldLim = (CNT_W+1)'(HOLD_CYC);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W:0]   hold_dist;
    logic             hold_short;

    always_comb begin
        // A set on the same edge as rd_i is zero cycles after it.
        hold_dist  = rd_i ? '0 : ({1'b0, hold_cnt_q} + {{CNT_W{1'b0}}, 1'b1});
        hold_short = (HOLD_CYC != 0) && (hold_dist < HoldLim);

        if (rd_i) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q == CntMax) begin
            hold_cnt_d = CntMax;
        end else begin
            hold_cnt_d = hold_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= CntMax;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sfq_dff_cell #(
            .SETUP_CYC (SETUP_CYC),
            .NDRO      (NDRO),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .set_i        (set_i[c]),
            .rd_i         (rd_i),
            .clr_i        (clr_i[c]),
            .flag_clr_i   (flag_clr_i),
            .hold_short_i (hold_short),
            .out_o        (out_o[c]),
            .state_o      (state_o[c]),
            .err_o        (err_o[c]),
            .viol_o       (viol_o[c])
        );
    end

endmodule

// File: tb/tb_sfq_dff_array.sv
// Directed bench for sfq_dff_array: a DRO and an NDRO instance share stimulus,
// a cycle-distance reference model fills a scoreboard that is drained after each edge.
module tb_sfq_dff_array;

    localparam int SETUP = 2;
    localparam int HOLD  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] set_i = '0;
    logic       rd_i = 1'b0;
    logic [3:0] clr_i = '0;
    logic       flag_clr_i = 1'b0;

    logic [3:0] out_d, st_d, err_d, viol_d;
    logic [3:0] out_n, st_n, err_n, viol_n;

    always #5 clk = ~clk;

    sfq_dff_array #(
        .N_CH(4), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .NDRO(1'b0), .CNT_W(4)
    ) u_dro (
        .clk(clk), .rst_n(rst_n), .set_i(set_i), .rd_i(rd_i), .clr_i(clr_i),
        .flag_clr_i(flag_clr_i), .out_o(out_d), .state_o(st_d), .err_o(err_d),
        .viol_o(viol_d)
    );

    sfq_dff_array #(
        .N_CH(4), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .NDRO(1'b1), .CNT_W(4)
    ) u_ndro (
        .clk(clk), .rst_n(rst_n), .set_i(set_i), .rd_i(rd_i), .clr_i(clr_i),
        .flag_clr_i(flag_clr_i), .out_o(out_n), .state_o(st_n), .err_o(err_n),
        .viol_o(viol_n)
    );

    typedef struct {
        int         k;
        logic [3:0] out;
        logic [3:0] st;
        logic [3:0] err;
        logic [3:0] viol;
    } exp_t;

    exp_t q[$];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int ndro_pulses = 0;

    logic [3:0] m_st[2], m_err[2], m_viol[2];
    int         m_last_set[2][4];
    int         m_last_rd[2];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = '0; m_err[k] = '0; m_viol[k] = '0;
            m_last_rd[k] = -1000;
            for (int c = 0; c < 4; c++) m_last_set[k][c] = -1000;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] s, input logic r,
                              input logic [3:0] c, input logic f);
        exp_t e;
        logic ndro;
        logic [3:0] ns;
        ndro = (k == 1);
        e.k = k;
        for (int ch = 0; ch < 4; ch++) begin
            logic sv, hv, ev;
            e.out[ch] = r && m_st[k][ch];
            sv = (SETUP > 0) && r &&
                 (s[ch] || (m_st[k][ch] && (cyc - m_last_set[k][ch]) < SETUP));
            hv = (HOLD > 0) && s[ch] && (cyc - m_last_rd[k]) < HOLD;
            ev = s[ch] && m_st[k][ch] && (ndro || !r);
            if (c[ch])               ns[ch] = 1'b0;
            else if (s[ch])          ns[ch] = 1'b1;
            else if (r && !ndro)     ns[ch] = 1'b0;
            else                     ns[ch] = m_st[k][ch];
            e.err[ch]  = (m_err[k][ch] && !f) || ev;
            e.viol[ch] = (m_viol[k][ch] && !f) || sv || hv;
            if (s[ch]) m_last_set[k][ch] = cyc;
        end
        if (r) m_last_rd[k] = cyc;
        m_st[k] = ns; m_err[k] = e.err; m_viol[k] = e.viol;
        e.st = ns;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] s, input logic r, input logic [3:0] c,
                        input logic f);
        exp_t e;
        @(negedge clk);
        set_i = s; rd_i = r; clr_i = c; flag_clr_i = f;
        model_step(0, s, r, c, f);
        model_step(1, s, r, c, f);
        cyc++;
        @(posedge clk);
        #1;
        set_i = '0; rd_i = 1'b0; clr_i = '0; flag_clr_i = 1'b0;
        if (out_n[0]) ndro_pulses++;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.k == 0) begin
                check($sformatf("c%0d dro out", cyc), out_d, e.out);
                check($sformatf("c%0d dro state", cyc), st_d, e.st);
                check($sformatf("c%0d dro err", cyc), err_d, e.err);
                check($sformatf("c%0d dro viol", cyc), viol_d, e.viol);
            end else begin
                check($sformatf("c%0d ndro out", cyc), out_n, e.out);
                check($sformatf("c%0d ndro state", cyc), st_n, e.st);
                check($sformatf("c%0d ndro err", cyc), err_n, e.err);
                check($sformatf("c%0d ndro viol", cyc), viol_n, e.viol);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dro out"}, out_d, 4'h0);
        check({tag, " dro state"}, st_d, 4'h0);
        check({tag, " dro err"}, err_d, 4'h0);
        check({tag, " dro viol"}, viol_d, 4'h0);
        check({tag, " ndro out"}, out_n, 4'h0);
        check({tag, " ndro state"}, st_n, 4'h0);
        check({tag, " ndro err"}, err_n, 4'h0);
        check({tag, " ndro viol"}, viol_n, 4'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // DRO basic
        step(4'b0001, 1'b0, 4'h0, 1'b0);
        idle(9);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        check("dro basic pulse", out_d, 4'b0001);
        idle(1);
        check("dro basic pulse width", out_d, 4'b0000);

        // Double set
        step(4'b0100, 1'b0, 4'h0, 1'b0);
        idle(3);
        step(4'b0100, 1'b0, 4'h0, 1'b0);
        idle(5);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        check("double set err", err_d, 4'b0100);
        idle(1);

        // Setup violation, then same-edge set/rd on ch0
        step(4'b0010, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        check("setup viol pulse", out_d & 4'b0010, 4'b0010);
        step(4'h0, 1'b0, 4'h0, 1'b1);
        step(4'b0001, 1'b1, 4'h0, 1'b0);
        check("same edge set/rd", {out_d[0], st_d[0], viol_d[0]}, 4'b0011);
        idle(3);
        step(4'h0, 1'b1, 4'h0, 1'b1);

        // Hold window
        step(4'b1000, 1'b1, 4'h0, 1'b0);
        check("hold viol", viol_d & 4'b1000, 4'b1000);
        step(4'h0, 1'b0, 4'hF, 1'b1);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        idle(1);
        step(4'b1000, 1'b0, 4'h0, 1'b0);
        check("hold ok", viol_d & 4'b1000, 4'b0000);

        // NDRO repeated readout and clear
        step(4'h0, 1'b0, 4'hF, 1'b1);
        step(4'b0001, 1'b0, 4'h0, 1'b0);
        idle(2);
        ndro_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 1'b1, 4'h0, 1'b0);
            idle(1);
        end
        check("ndro pulse count", 4'(ndro_pulses), 4'd3);
        step(4'h0, 1'b0, 4'b0001, 1'b0);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        check("ndro cleared", out_n, 4'h0);

        // Async reset with full state and flags
        step(4'hF, 1'b0, 4'h0, 1'b0);
        step(4'hF, 1'b0, 4'h0, 1'b0);
        idle(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag clear loses to a same-edge error
        step(4'b0001, 1'b0, 4'h0, 1'b0);
        step(4'b0001, 1'b0, 4'h0, 1'b1);
        check("flag clr vs err", err_d & 4'b0001, 4'b0001);

        // Sparse random traffic
        for (int i = 0; i < 60; i++) begin
            logic [3:0] s, c;
            s = 4'($urandom) & 4'($urandom);
            c = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step(s, ($urandom_range(0, 3) == 0), c, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
